// File: rtl/spi_slave_gen.sv
// SPI slave: deserialises {cmd, payload} frames from MOSI and serialises read data onto MISO,
// with abort detection, a read-data timeout and a MISO output-enable.
module spi_slave_gen #(
   parameter int unsigned DATA_W     = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned RD_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic              miso_oe,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned FRAME_W = DATA_W + 2;
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
   localparam int unsigned WT_W    = $clog2(RD_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [WT_W-1:0]  WT_LAST   = WT_W'(RD_TIMEOUT - 1);
   localparam logic [WT_W-1:0]  WT_ONE    = WT_W'(1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_CHK_CMD   = 3'd1;
   localparam logic [2:0] S_WRITE     = 3'd2;
   localparam logic [2:0] S_READ_ADD  = 3'd3;
   localparam logic [2:0] S_READ_DATA = 3'd4;
   localparam logic [2:0] S_RD_WAIT   = 3'd5;
   localparam logic [2:0] S_RD_SHIFT  = 3'd6;
   localparam logic [2:0] S_WAIT_SS   = 3'd7;

   logic [2:0]         state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [WT_W-1:0]    wait_cnt;
   logic [FRAME_W-1:0] rx_sh;
   logic [DATA_W-1:0]  tx_sh;
   logic               rd_addr_seen;

   logic [FRAME_W-1:0] rx_sh_next;
   logic [DATA_W-1:0]  tx_sh_next;
   logic               tx_first_bit;
   logic               tx_next_bit;

   always_comb begin
      rx_sh_next   = MSB_FIRST ? {rx_sh[FRAME_W-2:0], MOSI} : {MOSI, rx_sh[FRAME_W-1:1]};
      tx_sh_next   = MSB_FIRST ? {tx_sh[DATA_W-2:0], 1'b0} : {1'b0, tx_sh[DATA_W-1:1]};
      tx_first_bit = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
      tx_next_bit  = MSB_FIRST ? tx_sh_next[DATA_W-1] : tx_sh_next[0];
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         bit_cnt      <= '0;
         wait_cnt     <= '0;
         rx_sh        <= '0;
         tx_sh        <= '0;
         rd_addr_seen <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         MISO         <= 1'b0;
         miso_oe      <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            S_IDLE: begin
               MISO    <= 1'b0;
               miso_oe <= 1'b0;
               if (!SS_n) state <= S_CHK_CMD;
            end
            S_CHK_CMD: begin
               if (SS_n) begin
                  state <= S_IDLE;
               end else begin
                  bit_cnt <= FRAME_CNT;
                  if (!MOSI)            state <= S_WRITE;
                  else if (rd_addr_seen) state <= S_READ_DATA;
                  else                   state <= S_READ_ADD;
               end
            end
            S_WRITE, S_READ_ADD, S_READ_DATA: begin
               // bit_cnt == 0 is the completion cycle; SS_n rising together with the last bit still completes
               if (bit_cnt == '0) begin
                  rx_data  <= rx_sh;
                  rx_valid <= 1'b1;
                  if (state == S_READ_ADD) rd_addr_seen <= 1'b1;
                  if (SS_n) begin
                     state <= S_IDLE;
                  end else if (state == S_READ_DATA) begin
                     state    <= S_RD_WAIT;
                     wait_cnt <= '0;
                  end else begin
                     state <= S_WAIT_SS;
                  end
               end else if (SS_n && bit_cnt != CNT_ONE) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  rx_sh   <= rx_sh_next;
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end
            S_RD_WAIT: begin
               if (SS_n) begin
                  state <= S_IDLE;
               end else if (tx_valid) begin
                  tx_sh   <= tx_data;
                  MISO    <= tx_first_bit;
                  miso_oe <= 1'b1;
                  bit_cnt <= DATA_CNT;
                  state   <= S_RD_SHIFT;
               end else if (wait_cnt == WT_LAST) begin
                  frame_err    <= 1'b1;
                  rd_addr_seen <= 1'b0;
                  state        <= S_WAIT_SS;
               end else begin
                  wait_cnt <= wait_cnt + WT_ONE;
               end
            end
            S_RD_SHIFT: begin
               // first bit was already driven on acceptance, so bit_cnt == 1 means the last bit has been shown
               if (SS_n || bit_cnt == CNT_ONE) begin
                  MISO         <= 1'b0;
                  miso_oe      <= 1'b0;
                  rd_addr_seen <= 1'b0;
                  frame_err    <= SS_n && (bit_cnt != CNT_ONE);
                  state        <= SS_n ? S_IDLE : S_WAIT_SS;
               end else begin
                  tx_sh   <= tx_sh_next;
                  MISO    <= tx_next_bit;
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end
            S_WAIT_SS: begin
               MISO    <= 1'b0;
               miso_oe <= 1'b0;
               if (SS_n) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: MSB-first DATA_W=8 instance plus an LSB-first DATA_W=16 instance.
module tb_spi_slave_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        SS_n, MOSI, tx_valid;
   logic [7:0]  tx_data;
   logic        MISO, miso_oe, rx_valid, frame_err, busy;
   logic [9:0]  rx_data;

   logic        SS_n2, MOSI2;
   logic        MISO2, miso_oe2, rx_valid2, frame_err2, busy2;
   logic [17:0] rx_data2;
   logic [15:0] tx_data2;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   spi_slave_gen #(.DATA_W(8), .MSB_FIRST(1'b1), .RD_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .miso_oe(miso_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
      .frame_err(frame_err), .busy(busy)
   );

   spi_slave_gen #(.DATA_W(16), .MSB_FIRST(1'b0), .RD_TIMEOUT(15)) dut_lsb (
      .clk(clk), .rst(rst), .SS_n(SS_n2), .MOSI(MOSI2), .MISO(MISO2), .miso_oe(miso_oe2),
      .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_data(tx_data2), .tx_valid(1'b0),
      .frame_err(frame_err2), .busy(busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives SS_n low (edge 0), the R/W bit (edge 1) and the first nbits body bits MSB first.
   task automatic send_head(input logic rw, input logic [9:0] body, input int unsigned nbits);
      SS_n = 1'b0;
      step();
      MOSI = rw;
      step();
      for (int unsigned i = 0; i < nbits; i++) begin
         MOSI = body[9-i];
         step();
      end
   endtask

   task automatic release_ss();
      SS_n = 1'b1;
      MOSI = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic       fe_seen, oe_seen;
      logic [7:0] exp_byte;
      logic [17:0] body2;

      rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
      SS_n2 = 1'b1; MOSI2 = 1'b0; tx_data2 = '0;
      step(); step();
      check("rst_miso",      {31'd0, MISO},      32'd0);
      check("rst_oe",        {31'd0, miso_oe},   32'd0);
      check("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_rx_data",   {22'd0, rx_data},   32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      rst = 1'b0;
      step();

      // Write frame: rx_valid after edge 12 only
      send_head(1'b0, 10'h0A5, 10);
      check("wr_no_early_valid", {31'd0, rx_valid}, 32'd0);
      step();
      check("wr_rx_valid",  {31'd0, rx_valid},  32'd1);
      check("wr_rx_data",   {22'd0, rx_data},   32'h0A5);
      check("wr_frame_err", {31'd0, frame_err}, 32'd0);
      check("wr_miso",      {31'd0, MISO},      32'd0);
      step();
      check("wr_valid_pulse", {31'd0, rx_valid}, 32'd0);
      check("wr_wait_busy",   {31'd0, busy},     32'd1);
      release_ss();
      check("wr_idle", {31'd0, busy}, 32'd0);

      // Read address then read data
      send_head(1'b1, 10'h23C, 10);
      step();
      check("ra_rx_data", {22'd0, rx_data}, 32'h23C);
      check("ra_seen",    {31'd0, dut.rd_addr_seen}, 32'd1);
      release_ss();
      send_head(1'b1, 10'h300, 10);
      step();
      check("rd_rx_valid", {31'd0, rx_valid}, 32'd1);
      check("rd_rx_data",  {22'd0, rx_data},  32'h300);
      step();
      tx_data = 8'hC3; tx_valid = 1'b1;
      step();
      // tx_valid held with different data during RD_SHIFT must be ignored
      tx_data = 8'hFF;
      exp_byte = 8'hC3;
      for (int unsigned i = 0; i < 8; i++) begin
         check($sformatf("rd_miso_%0d", i), {31'd0, MISO}, {31'd0, exp_byte[7-i]});
         check($sformatf("rd_oe_%0d", i),   {31'd0, miso_oe}, 32'd1);
         step();
      end
      tx_valid = 1'b0;
      check("rd_end_oe",   {31'd0, miso_oe}, 32'd0);
      check("rd_end_miso", {31'd0, MISO},    32'd0);
      check("rd_end_seen", {31'd0, dut.rd_addr_seen}, 32'd0);
      check("rd_end_err",  {31'd0, frame_err}, 32'd0);
      release_ss();

      // Abort after 5 payload bits of a write
      send_head(1'b0, 10'h155, 5);
      release_ss();
      check("ab_frame_err", {31'd0, frame_err}, 32'd1);
      check("ab_no_valid",  {31'd0, rx_valid},  32'd0);
      check("ab_idle",      {31'd0, busy},      32'd0);
      step();
      check("ab_err_pulse", {31'd0, frame_err}, 32'd0);

      // SS_n rises together with the last body bit: frame still completes
      send_head(1'b0, 10'h3C1, 9);
      MOSI = 1'b1; SS_n = 1'b1;
      step();
      check("sim_no_early_err", {31'd0, frame_err}, 32'd0);
      step();
      check("sim_rx_valid",  {31'd0, rx_valid},  32'd1);
      check("sim_rx_data",   {22'd0, rx_data},   32'h3C1);
      check("sim_frame_err", {31'd0, frame_err}, 32'd0);
      check("sim_idle",      {31'd0, busy},      32'd0);
      MOSI = 1'b0;
      step();

      // Read timeout: 15 cycles in RD_WAIT without tx_valid
      send_head(1'b1, 10'h011, 10);
      step();
      release_ss();
      send_head(1'b1, 10'h300, 10);
      step();
      fe_seen = 1'b0; oe_seen = 1'b0;
      for (int unsigned k = 0; k < 14; k++) begin
         step();
         fe_seen |= frame_err;
         oe_seen |= miso_oe;
      end
      check("to_no_early_err", {31'd0, fe_seen}, 32'd0);
      step();
      check("to_frame_err", {31'd0, frame_err}, 32'd1);
      check("to_oe",        {31'd0, (oe_seen | miso_oe)}, 32'd0);
      check("to_seen",      {31'd0, dut.rd_addr_seen}, 32'd0);
      step();
      check("to_err_pulse", {31'd0, frame_err}, 32'd0);
      release_ss();

      // Reset after 3 MISO bits
      send_head(1'b1, 10'h022, 10);
      step();
      release_ss();
      send_head(1'b1, 10'h300, 10);
      step();
      tx_data = 8'hA5; tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      exp_byte = 8'hA5;
      for (int unsigned i = 0; i < 3; i++) begin
         check($sformatf("rs_miso_%0d", i), {31'd0, MISO}, {31'd0, exp_byte[7-i]});
         if (i < 2) step();
      end
      rst = 1'b1; SS_n = 1'b1;
      step();
      rst = 1'b0;
      check("rs_miso",    {31'd0, MISO},      32'd0);
      check("rs_oe",      {31'd0, miso_oe},   32'd0);
      check("rs_busy",    {31'd0, busy},      32'd0);
      check("rs_rx_data", {22'd0, rx_data},   32'd0);
      check("rs_err",     {31'd0, frame_err}, 32'd0);
      step();
      check("rs_err_after", {31'd0, frame_err}, 32'd0);

      // LSB-first DATA_W=16 write frame
      body2 = 18'h2_1234;
      SS_n2 = 1'b0;
      step();
      MOSI2 = 1'b0;
      step();
      for (int unsigned i = 0; i < 18; i++) begin
         MOSI2 = body2[i];
         step();
      end
      check("lsb_no_early_valid", {31'd0, rx_valid2}, 32'd0);
      step();
      check("lsb_rx_valid",  {31'd0, rx_valid2},  32'd1);
      check("lsb_rx_data",   {14'd0, rx_data2},   32'h2_1234);
      check("lsb_frame_err", {31'd0, frame_err2}, 32'd0);
      SS_n2 = 1'b1; MOSI2 = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
